// File: rtl/div_arbiter.sv
// div_arbiter: round-robin share of one start/done divider core; DIV_ARB_WATCHDOG_EN adds a WAIT watchdog
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_dividend,
  input  logic [NREQ*WIDTH-1:0]    req_divisor,
  output logic [NREQ-1:0]          resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [WIDTH-1:0]         resp_quotient,
  output logic [WIDTH-1:0]         resp_remainder,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic                     div_done,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_id, r_rid, w_gid;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_q, r_r, w_dvd, w_dvs;
  logic r_err, w_found, w_zero, w_tmo, w_acc, w_fin;
`ifdef DIV_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  // count WAIT cycles; held at zero elsewhere so every WAIT starts from 0
  always_ff @(posedge clk)
    if (reset) r_cnt <= '0;
    else r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
  assign w_tmo = (r_state == WAIT) && !div_done && (r_cnt == CW'(TIMEOUT - 1));
`else
  logic w_unused;
  assign w_unused = ^TIMEOUT;
  assign w_tmo = 1'b0;
`endif
  // first valid lane searching upward from r_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gid = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_gid = IW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end
  assign w_dvd = req_dividend[w_gid*WIDTH +: WIDTH];
  assign w_dvs = req_divisor[w_gid*WIDTH +: WIDTH];
  assign w_zero = (w_dvs == '0);
  assign w_acc = (r_state == IDLE) && w_found;
  assign w_fin = (r_state == WAIT) && (div_done || w_tmo);
  // next-state: zero divisor skips the core entirely
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_found) w_next = w_zero ? RESP : ISSUE;
      ISSUE: w_next = WAIT;
      WAIT:  if (div_done || w_tmo) w_next = RESP;
      RESP:  w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // operand latch, result capture and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_rid <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_acc) begin
        r_id  <= w_gid;
        r_dvd <= w_dvd;
        r_dvs <= w_dvs;
        if (w_zero) begin
          r_q   <= '1;
          r_r   <= w_dvd;
          r_err <= 1'b1;
          r_rid <= w_gid;
        end
      end
      if (w_fin) begin
        r_q   <= div_done ? div_quotient : '0;
        r_r   <= div_done ? div_remainder : '0;
        r_err <= !div_done;
        r_rid <= r_id;
      end
      if (r_state == RESP) r_ptr <= IW'((int'(r_id) + 1) % NREQ);
    end
  end
  assign req_ready      = w_acc ? NREQ'(1) << w_gid : '0;
  assign resp_valid     = (r_state == RESP) ? NREQ'(1) << r_rid : '0;
  assign resp_id        = r_rid;
  assign resp_quotient  = r_q;
  assign resp_remainder = r_r;
  assign resp_err       = r_err;
  assign busy           = (r_state != IDLE);
  assign div_start      = (r_state == ISSUE);
  assign div_dividend   = r_dvd;
  assign div_divisor    = r_dvs;
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: scoreboard bench for div_arbiter with a behavioural divider core
module tb_div_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req_valid, req_ready, resp_valid;
  logic [127:0] req_dividend = '0, req_divisor = '0;
  logic [1:0] resp_id;
  logic [31:0] resp_quotient, resp_remainder, div_dividend, div_divisor;
  logic [31:0] div_quotient = '0, div_remainder = '0;
  logic resp_err, busy, div_start, div_done = 1'b0;
  typedef struct {int id; logic [31:0] q; logic [31:0] r; logic err; int lat;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, core_d = 3, n_start = 0, last_acc = 0;
  int posted[4] = '{0, 0, 0, 0};
  int taken[4] = '{0, 0, 0, 0};
  int acc_cyc[4] = '{0, 0, 0, 0};

  div_arbiter #(.NREQ(4), .WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_err(resp_err), .busy(busy), .div_start(div_start), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_done(div_done), .div_quotient(div_quotient),
    .div_remainder(div_remainder));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb for (int i = 0; i < 4; i++) req_valid[i] = (posted[i] != taken[i]);

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // accept watcher: a transfer in cycle T drops that lane's valid just after the edge
  always begin
    logic [3:0] hit;
    @(negedge clk);
    hit = req_valid & req_ready;
    if (hit != 0) begin
      for (int i = 0; i < 4; i++) if (hit[i]) acc_cyc[i] = cyc;
      last_acc = cyc;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (hit[i]) taken[i]++;
    end
  end

  // behavioural core: done D cycles after the start cycle
  always begin
    logic [31:0] a, b;
    int d;
    @(negedge clk);
    if (div_start) begin
      a = div_dividend;
      b = div_divisor;
      d = core_d;
      repeat (d) @(negedge clk);
      div_done = 1'b1;
      div_quotient = a / b;
      div_remainder = a % b;
      @(negedge clk);
      div_done = 1'b0;
    end
  end

  // start checker: start exactly one cycle after the accept
  always @(negedge clk) if (div_start) begin
    n_start++;
    chk("start_latency", 64'(cyc - last_acc), 1);
  end

  // response monitor
  always @(negedge clk) if (resp_valid != 0) begin
    if (sb.size() == 0) chk("unexpected_resp", resp_valid, 0);
    else begin
      exp_t e;
      e = sb.pop_front();
      chk("resp_valid", resp_valid, 4'b1 << e.id);
      chk("resp_id", resp_id, e.id);
      chk("resp_quotient", resp_quotient, e.q);
      chk("resp_remainder", resp_remainder, e.r);
      chk("resp_err", resp_err, e.err);
      chk("resp_latency", 64'(cyc - acc_cyc[e.id]), e.lat);
    end
  end

  task automatic post(input int l, input logic [31:0] a, input logic [31:0] b);
    req_dividend[l*32 +: 32] = a;
    req_divisor[l*32 +: 32] = b;
    posted[l]++;
  endtask

  task automatic expect_resp(input int id, input logic [31:0] q, input logic [31:0] r, input logic err, input int lat);
    exp_t e;
    e.id = id; e.q = q; e.r = r; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic drain(input string n);
    int k = 0;
    while ((sb.size() != 0 || busy || req_valid != 0) && k < 300) begin
      @(posedge clk);
      k++;
    end
    chk(n, k < 300, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_taken(input int l, input int was);
    int k = 0;
    while (taken[l] == was && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_accept", k < 100, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int s, t;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_outs", {req_ready, resp_valid, resp_id, resp_quotient[7:0], resp_remainder[7:0], resp_err, busy, div_start}, 0);
    chk("reset_ops", {div_dividend, div_divisor}, 0);
    core_d = 3;
    expect_resp(0, 3, 1, 0, 5);
    post(0, 10, 3);
    drain("drain_single");
    do_reset();
    core_d = 2;
    expect_resp(0, 20, 0, 0, 4);
    expect_resp(1, 7, 2, 0, 4);
    expect_resp(2, 32, 0, 0, 4);
    expect_resp(3, 2, 2, 0, 4);
    post(0, 100, 5); post(1, 30, 4); post(2, 256, 8); post(3, 8, 3);
    drain("drain_all4");
    expect_resp(0, 1, 0, 0, 4);
    expect_resp(3, 2, 2, 0, 4);
    post(3, 12, 5); post(0, 7, 7);
    drain("drain_ptr0");
    s = n_start;
    expect_resp(2, 32'hFFFF_FFFF, 40, 1, 1);
    post(2, 40, 0);
    drain("drain_div0");
    chk("div0_no_start", n_start, s);
    expect_resp(1, 7, 1, 0, 4);
    post(1, 50, 7);
    drain("drain_lane1");
    expect_resp(3, 5, 1, 0, 4);
    expect_resp(1, 3, 2, 0, 4);
    expect_resp(3, 5, 1, 0, 4);
    expect_resp(1, 3, 2, 0, 4);
    t = taken[3];
    post(1, 17, 5); post(3, 21, 4);
    wait_taken(3, t);
    post(3, 21, 4);
    t = taken[1];
    wait_taken(1, t);
    post(1, 17, 5);
    drain("drain_fair");
    core_d = 10;
    s = n_start;
    post(0, 100, 7);
    t = 0;
    while (n_start == s && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("reset_test_start", t < 50, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midreset_outs", {resp_valid, resp_id, resp_err, busy, div_start, req_ready}, 0);
    chk("midreset_res", {resp_quotient, resp_remainder}, 0);
    chk("midreset_ops", {div_dividend, div_divisor}, 0);
    repeat (15) @(posedge clk);
    #1;
    chk("midreset_idle", busy, 0);
    core_d = 3;
    expect_resp(0, 3, 0, 0, 5);
    post(0, 9, 3);
    drain("drain_after_reset");
    core_d = 20;
`ifdef DIV_ARB_WATCHDOG_EN
    expect_resp(1, 0, 0, 1, 10);
`else
    expect_resp(1, 10, 0, 0, 22);
`endif
    post(1, 50, 5);
    drain("drain_watchdog");
    repeat (30) @(posedge clk);
    #1;
    chk("late_done_ignored", busy, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler sharing one multi-cycle divider core (`divYR` family, start/done handshake) between NREQ requesters. It accepts one request at a time over a valid/ready handshake and sequences the divider through a start pulse. It returns the quotient and remainder to the winning requester with a one-hot response strobe. Divide-by-zero is resolved locally without engaging the core. It sits between the requesting datapath units and the single divider instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- TIMEOUT, 64, watchdog limit in cycles; used only with DIV_ARB_WATCHDOG_EN

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot grant/accept; transfer when req_valid[i] & req_ready[i]
- req_dividend  in  NREQ*WIDTH  lane i at [i*WIDTH +: WIDTH]
- req_divisor  in  NREQ*WIDTH  lane i at [i*WIDTH +: WIDTH]
- resp_valid  out  NREQ  one-hot, one-cycle response strobe
- resp_id  out  $clog2(NREQ)  index of the responding requester
- resp_quotient  out  WIDTH  result quotient
- resp_remainder  out  WIDTH  result remainder
- resp_err  out  1  divide-by-zero or watchdog abort
- busy  out  1  high in any state except IDLE
- div_start  out  1  one-cycle start pulse to the core
- div_dividend  out  WIDTH  latched operand, held stable from the div_start cycle to div_done
- div_divisor  out  WIDTH  latched operand, held stable from the div_start cycle to div_done
- div_done  in  1  core completion strobe
- div_quotient  in  WIDTH  core result, valid with div_done
- div_remainder  in  WIDTH  core result, valid with div_done

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the first asserted req_valid searching upward from rr_ptr, with wrap-around.
  - req_ready is asserted combinationally, one-hot, for the winner only, and only in IDLE.
  - On transfer, latch the operands and id.
  - Divisor == 0: go to RESP.
  - Otherwise: go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On div_done, capture div_quotient and div_remainder, then go to RESP.
  - div_done seen in any other state is ignored.
- RESP:
  - resp_valid[id]=1 for one cycle.
  - resp_quotient, resp_remainder, resp_id and resp_err are registered and held until the next RESP.
  - rr_ptr is set to (id+1) mod NREQ, then go to IDLE.
- Divide-by-zero:
  - quotient = all ones, remainder = dividend, resp_err=1.
  - The core is never started.
- Requesters hold valid and operands stable until accepted. Responses have no backpressure.
- A requester may re-request in the cycle after its resp_valid. It is still subject to round-robin order.

## Timing
- Reset:
  - All outputs are 0, state is IDLE, rr_ptr is 0.
  - An in-flight request is dropped with no response. A core result arriving after reset is ignored.
- Latency, normal case:
  - Accept at cycle T.
  - div_start at T+1.
  - If div_done arrives at T+1+D (D≥1), resp_valid is at T+2+D.
- Latency, zero divisor: resp_valid at T+1.
- Throughput: at most one request in flight. The next accept is no earlier than the cycle after RESP.
- Fairness: with all requesters continuously valid, grants are strictly 0,1,…,NREQ-1,0,…. Any requester waits at most NREQ-1 services.
- Simultaneous requests in IDLE are resolved by rr_ptr only. A newly asserted req_valid never preempts an accepted request.

## Configuration
- Macro: DIV_ARB_WATCHDOG_EN.
- When defined:
  - A counter is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without div_done, go to RESP with quotient=0, remainder=0, resp_err=1.
  - A div_done that arrives later is ignored.
- When undefined: no counter. WAIT lasts until div_done indefinitely, and the TIMEOUT parameter is unused.

## Test plan
- Single request 10/3 on lane 0, core D=3 → req_ready[0] at T, div_start at T+1, resp_valid=0001 at T+5, q=3, r=1, err=0.
- All 4 lanes valid: 100/5, 30/4, 256/8, 8/3 → responses in lane order 0,1,2,3 with (20,0), (7,2), (32,0), (2,2); rr_ptr returns to 0.
- Lane 2 divisor 0, dividend 40 → no div_start, resp_valid=0100 at T+1, q=0xFFFFFFFF, r=40, err=1.
- Lanes 1 and 3 continuously valid, rr_ptr=2 → grant 3, then 1, then 3 (alternation, no starvation).
- reset asserted in WAIT, then div_done pulsed → all outputs 0 next cycle, no resp_valid, IDLE accepts a new 9/3 → q=3, r=0.
- With DIV_ARB_WATCHDOG_EN, TIMEOUT=8, core never answers → resp_valid 8 cycles into WAIT with q=0, r=0, err=1; a later div_done is ignored.
